// File: rtl/lcd_reset_seq.sv
// LCD panel reset sequencer.
// Drives the panel reset line through a pre-delay, an active pulse and a
// recovery wait. A recovery-only mode skips straight to the wait, which is
// the step needed after a software reset command. All outputs are decoded
// from registered state, so no input reaches an output combinationally.
module lcd_reset_seq #(
  parameter int CYC_PRE     = 4,        // line held inactive before the pulse
  parameter int CYC_PULSE   = 40,       // active pulse width
  parameter int CYC_RECOVER = 480_000,  // post-reset recovery wait
  parameter int ACTIVE_LOW  = 1,        // 1: asserted level is 0
  parameter int AUTO_START  = 1         // 1: run once automatically after rst release
) (
  input  logic clk,
  input  logic rst,        // asynchronous, active-low
  input  logic i_start,
  input  logic i_mode,     // 0: full hardware sequence, 1: recovery only
  input  logic i_abort,
  output logic o_lcd_rst,
  output logic o_busy,
  output logic o_done
);

  // One counter serves every phase, so it is sized for the longest one.
  localparam int MAX_AB = (CYC_PRE > CYC_PULSE) ? CYC_PRE : CYC_PULSE;
  localparam int MAX_C  = (MAX_AB > CYC_RECOVER) ? MAX_AB : CYC_RECOVER;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] LD_PRE     = CW'(CYC_PRE - 1);
  localparam logic [CW-1:0] LD_PULSE   = CW'(CYC_PULSE - 1);
  localparam logic [CW-1:0] LD_RECOVER = CW'(CYC_RECOVER - 1);
  localparam logic          AUTO_INIT  = (AUTO_START != 0);
  localparam logic          LOW_ACTIVE = (ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    ASSERT  = 3'd2,
    RECOVER = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            mode_reg, mode_next;
  logic            auto_reg, auto_next;

  // State, phase counter, captured mode and the one-shot auto-start flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      auto_reg  <= AUTO_INIT;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      auto_reg  <= auto_next;
    end
  end

  // Next-state logic: each phase loads (length - 1) on entry and exits at 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    // Auto-start only gets the first edge after rst release, used or not.
    auto_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_abort) begin
          state_next = IDLE;
        end else if (auto_reg) begin
          state_next = PRE;
          cnt_next   = LD_PRE;
          mode_next  = 1'b0;
        end else if (i_start) begin
          mode_next = i_mode;
          if (i_mode) begin
            state_next = RECOVER;
            cnt_next   = LD_RECOVER;
          end else begin
            state_next = PRE;
            cnt_next   = LD_PRE;
          end
        end
      end
      PRE: begin
        if (i_abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = ASSERT;
          cnt_next   = LD_PULSE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ASSERT: begin
        if (i_abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = RECOVER;
          cnt_next   = LD_RECOVER;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RECOVER: begin
        if (i_abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        // Start requests here are dropped, not queued.
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    logic line_asserted;
    // A recovery-only run never reaches ASSERT; the mode gate keeps the
    // line inactive even if that ever stopped holding.
    line_asserted = (state_reg == ASSERT) && !mode_reg;
    o_lcd_rst     = line_asserted ^ LOW_ACTIVE;
    o_busy        = (state_reg == PRE) || (state_reg == ASSERT) || (state_reg == RECOVER);
    o_done        = (state_reg == DONE);
  end

endmodule

// File: tb/tb_lcd_reset_seq.sv
// Directed bench for lcd_reset_seq with short phase lengths (2/4/8).
// dut1: ACTIVE_LOW=1, AUTO_START=0. dut2: ACTIVE_LOW=0, AUTO_START=1.
module tb_lcd_reset_seq;

  logic clk = 1'b0;
  logic rst, i_start, i_mode, i_abort;
  logic o_lcd_rst, o_busy, o_done;
  logic rst2, start2, mode2, abort2;
  logic lcd2, busy2, done2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lcd_reset_seq #(
    .CYC_PRE(2), .CYC_PULSE(4), .CYC_RECOVER(8), .ACTIVE_LOW(1), .AUTO_START(0)
  ) dut1 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_abort(i_abort),
    .o_lcd_rst(o_lcd_rst), .o_busy(o_busy), .o_done(o_done)
  );

  lcd_reset_seq #(
    .CYC_PRE(2), .CYC_PULSE(4), .CYC_RECOVER(8), .ACTIVE_LOW(0), .AUTO_START(1)
  ) dut2 (
    .clk(clk), .rst(rst2), .i_start(start2), .i_mode(mode2), .i_abort(abort2),
    .o_lcd_rst(lcd2), .o_busy(busy2), .o_done(done2)
  );

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({o_lcd_rst, o_busy, o_done} !== 3'b100) begin
      bad++;
      $display("FAIL reset1 lcd/busy/done=%b%b%b expected 100", o_lcd_rst, o_busy, o_done);
    end
    total++;
    if ({lcd2, busy2, done2} !== 3'b000) begin
      bad++;
      $display("FAIL reset2 lcd/busy/done=%b%b%b expected 000", lcd2, busy2, done2);
    end
    i_start = 1'b1;
    tick;
    tick;
    total++;
    if ({o_lcd_rst, o_busy, o_done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_hold lcd/busy/done=%b%b%b expected 100", o_lcd_rst, o_busy, o_done);
    end
    i_start = 1'b0;
    rst = 1'b1;
    tick;
    total++;
    if ({o_lcd_rst, o_busy, o_done} !== 3'b100) begin
      bad++;
      $display("FAIL no_auto lcd/busy/done=%b%b%b expected 100", o_lcd_rst, o_busy, o_done);
    end
    $display("test_reset done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_hw_seq;
    logic e_lcd, e_busy, e_done;
    i_start = 1'b1;
    i_mode  = 1'b0;
    tick;
    i_start = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      e_busy = (k <= 13);
      e_lcd  = !(k >= 2 && k <= 5);
      e_done = (k == 14);
      total++;
      if ({o_lcd_rst, o_busy, o_done} !== {e_lcd, e_busy, e_done}) begin
        bad++;
        $display("FAIL hw_seq k=%0d lcd/busy/done=%b%b%b expected %b%b%b",
                 k, o_lcd_rst, o_busy, o_done, e_lcd, e_busy, e_done);
      end
      tick;
    end
    $display("test_hw_seq done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_recover_only;
    logic e_busy, e_done;
    i_start = 1'b1;
    i_mode  = 1'b1;
    tick;
    i_start = 1'b0;
    i_mode  = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      e_busy = (k <= 7);
      e_done = (k == 8);
      total++;
      if ({o_lcd_rst, o_busy, o_done} !== {1'b1, e_busy, e_done}) begin
        bad++;
        $display("FAIL recover_only k=%0d lcd/busy/done=%b%b%b expected 1%b%b",
                 k, o_lcd_rst, o_busy, o_done, e_busy, e_done);
      end
      tick;
    end
    $display("test_recover_only done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_abort;
    logic e_lcd, e_busy, e_done;
    i_start = 1'b1;
    i_mode  = 1'b0;
    tick;
    i_start = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      e_lcd = !(k >= 2);
      total++;
      if ({o_lcd_rst, o_busy, o_done} !== {e_lcd, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL abort_pre k=%0d lcd/busy/done=%b%b%b expected %b10",
                 k, o_lcd_rst, o_busy, o_done, e_lcd);
      end
      if (k == 3) i_abort = 1'b1;
      tick;
    end
    i_abort = 1'b0;
    total++;
    if ({o_lcd_rst, o_busy, o_done} !== 3'b100) begin
      bad++;
      $display("FAIL abort_next lcd/busy/done=%b%b%b expected 100", o_lcd_rst, o_busy, o_done);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      total++;
      if ({o_busy, o_done} !== 2'b00) begin
        bad++;
        $display("FAIL abort_quiet k=%0d busy/done=%b%b expected 00", k, o_busy, o_done);
      end
    end
    // Abort beats start in IDLE.
    i_abort = 1'b1;
    i_start = 1'b1;
    tick;
    total++;
    if ({o_lcd_rst, o_busy, o_done} !== 3'b100) begin
      bad++;
      $display("FAIL abort_vs_start lcd/busy/done=%b%b%b expected 100", o_lcd_rst, o_busy, o_done);
    end
    i_abort = 1'b0;
    i_start = 1'b0;
    tick;
    // Fresh start after abort gives full timing.
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      e_busy = (k <= 13);
      e_lcd  = !(k >= 2 && k <= 5);
      e_done = (k == 14);
      total++;
      if ({o_lcd_rst, o_busy, o_done} !== {e_lcd, e_busy, e_done}) begin
        bad++;
        $display("FAIL abort_restart k=%0d lcd/busy/done=%b%b%b expected %b%b%b",
                 k, o_lcd_rst, o_busy, o_done, e_lcd, e_busy, e_done);
      end
      tick;
    end
    $display("test_abort done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_back_to_back;
    logic e_lcd, e_busy, e_done;
    int   n_done;
    n_done  = 0;
    i_mode  = 1'b0;
    i_start = 1'b1;
    tick;
    // Start stays high through the whole run, including the DONE cycle.
    for (int k = 0; k <= 15; k++) begin
      if (k == 15) i_start = 1'b0;
      e_busy = (k <= 13);
      e_lcd  = !(k >= 2 && k <= 5);
      e_done = (k == 14);
      if (o_done) n_done++;
      total++;
      if ({o_lcd_rst, o_busy, o_done} !== {e_lcd, e_busy, e_done}) begin
        bad++;
        $display("FAIL b2b k=%0d lcd/busy/done=%b%b%b expected %b%b%b",
                 k, o_lcd_rst, o_busy, o_done, e_lcd, e_busy, e_done);
      end
      tick;
    end
    for (int k = 0; k < 3; k++) begin
      if (o_done) n_done++;
      total++;
      if (o_busy !== 1'b0) begin
        bad++;
        $display("FAIL b2b_idle k=%0d busy=%b expected 0", k, o_busy);
      end
      tick;
    end
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL b2b_done_count got %0d expected 1", n_done);
    end
    $display("test_back_to_back done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_rst_mid;
    i_mode  = 1'b0;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    for (int k = 0; k < 8; k++) tick;
    total++;
    if ({o_lcd_rst, o_busy, o_done} !== 3'b110) begin
      bad++;
      $display("FAIL rst_mid_pre lcd/busy/done=%b%b%b expected 110", o_lcd_rst, o_busy, o_done);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({o_lcd_rst, o_busy, o_done} !== 3'b100) begin
      bad++;
      $display("FAIL rst_mid_async lcd/busy/done=%b%b%b expected 100", o_lcd_rst, o_busy, o_done);
    end
    tick;
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick;
      total++;
      if ({o_lcd_rst, o_busy, o_done} !== 3'b100) begin
        bad++;
        $display("FAIL rst_mid_after k=%0d lcd/busy/done=%b%b%b expected 100",
                 k, o_lcd_rst, o_busy, o_done);
      end
    end
    $display("test_rst_mid done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_auto;
    logic e_lcd, e_busy, e_done;
    rst2 = 1'b1;
    tick;
    for (int k = 0; k <= 18; k++) begin
      e_busy = (k <= 13);
      e_lcd  = (k >= 2 && k <= 5);
      e_done = (k == 14);
      total++;
      if ({lcd2, busy2, done2} !== {e_lcd, e_busy, e_done}) begin
        bad++;
        $display("FAIL auto k=%0d lcd/busy/done=%b%b%b expected %b%b%b",
                 k, lcd2, busy2, done2, e_lcd, e_busy, e_done);
      end
      tick;
    end
    $display("test_auto done: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    rst     = 1'b0;
    i_start = 1'b0;
    i_mode  = 1'b0;
    i_abort = 1'b0;
    rst2    = 1'b0;
    start2  = 1'b0;
    mode2   = 1'b0;
    abort2  = 1'b0;
    test_reset;
    test_hw_seq;
    test_recover_only;
    test_abort;
    test_back_to_back;
    test_rst_mid;
    test_auto;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
